lenet_accelerator: RTL and testbench
====================================

Name: lenet_accelerator

Overview:
- Fixed-point LeNet-style CNN inference engine for one 28x28 single-channel image, producing 10 class scores.
- Pipeline: conv1 (2 maps, 5x5, pad 2) -> ReLU -> maxpool 2x2 -> conv2 (2->2, 5x5, valid) -> ReLU -> maxpool 2x2 -> conv3 (2->10, 5x5, valid) -> ReLU -> fully connected 10x10.
- Sits behind a host that drives image and weight arrays as parallel ports and starts a run with a start pulse.
- Single shared MAC datapath; fully sequential.

Parameters:
- BITWIDTH, default 16: width of every signed data/weight word, two's complement.
- FRAC_BITS, default 8: fractional bits of the shared Q format; 1.0 = 2^FRAC_BITS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- image  in  [27:0][27:0] x BITWIDTH signed  input pixels [row][col].
- conv1_kernel  in  [1:0][4:0][4:0] x BITWIDTH  [out][row][col].
- conv2_kernel  in  [1:0][1:0][4:0][4:0] x BITWIDTH  [out][in][row][col].
- conv3_kernel  in  [9:0][1:0][4:0][4:0] x BITWIDTH  [out][in][row][col].
- connect_matrix  in  [9:0][9:0] x BITWIDTH  FC weights [out][in].
- output_vector  out  [9:0] x BITWIDTH  registered class scores.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when output_vector updates.

Behaviour:
- Reset: busy=0, done=0, all output_vector entries 0, FSM=IDLE, all counters and accumulator 0. Reset mid-run aborts immediately; partial results are discarded.
- Inputs are not captured; the host holds all input arrays stable while busy=1.
- States: IDLE, CONV1, POOL1, CONV2, POOL2, CONV3, FC, DONE.
- IDLE: start=1 -> CONV1, busy=1. start is ignored in every other state.
- Each conv/FC output element uses N MAC cycles plus 1 write cycle.
  - MAC cycle: acc += a*w, with a full 2*BITWIDTH product and a 2*BITWIDTH+8 accumulator.
  - Write cycle: result = acc >>> FRAC_BITS (arithmetic shift), saturated to BITWIDTH, ReLU applied (except FC), stored to internal buffer, acc cleared.
- conv1: 2x28x28 outputs, N=25. Out-of-range taps (row/col outside 0..27 after the -2 offset) contribute 0. 1568x26 = 40768 cycles.
- POOL1: 2x14x14 outputs, one per cycle, max of the 2x2 window. 392 cycles.
- conv2: 2x10x10 outputs, N=50, summed over both input channels. 10200 cycles.
- POOL2: 2x5x5 outputs. 50 cycles.
- conv3: 10 outputs (1x1), N=50. 510 cycles.
- FC: out[i] = sum_j connect_matrix[i][j]*conv3_out[j], N=10, no ReLU. Written into output_vector[i]. 110 cycles.
- DONE: one cycle with done=1 and busy=0 on exit, then IDLE.
- done is high during the 52031st cycle after the start-sampling edge, i.e. 52030 processing cycles plus the DONE cycle.
- output_vector holds its last result until the next run's FC writes. Entries are updated progressively during FC; they are valid only at done.
- Rounding: truncation toward minus infinity (arithmetic shift); no rounding bias.
- Internal buffers: 2x28x28, 2x14x14, 2x10x10, 2x5x5, 10 words; register or inferred RAM.

Optional Feature:
- Macro LENET_SATURATE_EN.
- Defined: every write-back clamps to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- Undefined: write-back keeps the low BITWIDTH bits of the shifted accumulator (wraparound). No other difference; latency is unchanged.

Test Plan:
- All-zero image and weights, start -> done after 52031 cycles, all 10 outputs 0, busy low afterwards.
- Image all 256; conv1 kernels center tap 256, else 0; conv2[o][i] center 256 when o==i, else 0; conv3[0][0] all taps 256, others 0; connect_matrix diagonal 256 -> output_vector[0]=6400, others 0.
- Same as previous, but connect_matrix diagonal -256 -> output_vector[0]=-6400 (no ReLU on FC).
- Same as the second scenario, but conv3[0][0] taps = 32512 -> output_vector[0]=32767 with LENET_SATURATE_EN; wrapped value without the macro.
- Second start pulse at cycle 5 of a run -> ignored; exactly one done at cycle 52031, same result.
- rst_n low at cycle 1000 -> busy=0, done=0, outputs 0 immediately. Restart -> correct result (6400), done 52031 cycles after the new start.

Source files
------------

// File: rtl/lenet_accelerator.sv
// lenet_accelerator
//
// Sequential fixed-point LeNet-style inference engine for one 28x28
// single-channel image. A single multiply-accumulate datapath walks the
// layers in order:
//   conv1 (2 maps, 5x5, pad 2) -> ReLU -> maxpool 2x2
//   conv2 (2->2, 5x5, valid)   -> ReLU -> maxpool 2x2
//   conv3 (2->10, 5x5, valid)  -> ReLU -> fully connected 10x10
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          run request, sampled only while idle
//   image          [row][col] input pixels
//   conv1_kernel   [out][row][col]
//   conv2_kernel   [out][in][row][col]
//   conv3_kernel   [out][in][row][col]
//   connect_matrix [out][in] fully connected weights
//   output_vector  registered class scores
//   busy           high while a layer is being processed
//   done           one-cycle pulse when output_vector holds a fresh result
//
// Configuration macro
//   LENET_SATURATE_EN  defined: write-backs clamp to the signed BITWIDTH range
//                      undefined: write-backs keep the low BITWIDTH bits
//
// All data words are signed two's complement with FRAC_BITS fractional bits.
// The host must hold every input array stable while busy is high.

module lenet_accelerator #(
    parameter int BITWIDTH  = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [27:0][27:0][BITWIDTH-1:0]           image,
    input  logic [1:0][4:0][4:0][BITWIDTH-1:0]        conv1_kernel,
    input  logic [1:0][1:0][4:0][4:0][BITWIDTH-1:0]   conv2_kernel,
    input  logic [9:0][1:0][4:0][4:0][BITWIDTH-1:0]   conv3_kernel,
    input  logic [9:0][9:0][BITWIDTH-1:0]             connect_matrix,
    output logic [9:0][BITWIDTH-1:0]                  output_vector,
    output logic                                      busy,
    output logic                                      done
);

    localparam int ACC_W = 2 * BITWIDTH + 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CONV1 = 3'd1;
    localparam logic [2:0] S_POOL1 = 3'd2;
    localparam logic [2:0] S_CONV2 = 3'd3;
    localparam logic [2:0] S_POOL2 = 3'd4;
    localparam logic [2:0] S_CONV3 = 3'd5;
    localparam logic [2:0] S_FC    = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

`ifdef LENET_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
`endif

    logic [2:0]                     state_q, state_d;
    logic [3:0]                     ch_q, ch_d;
    logic [4:0]                     row_q, row_d;
    logic [4:0]                     col_q, col_d;
    logic                           in_q, in_d;
    logic [2:0]                     kr_q, kr_d;
    logic [3:0]                     kc_q, kc_d;
    logic                           wr_q, wr_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [9:0][BITWIDTH-1:0]       output_vector_q, output_vector_d;

    // Intermediate feature maps, flattened as [channel][row][col]
    logic signed [BITWIDTH-1:0]     conv1_mem [0:1567];
    logic signed [BITWIDTH-1:0]     pool1_mem [0:391];
    logic signed [BITWIDTH-1:0]     conv2_mem [0:199];
    logic signed [BITWIDTH-1:0]     pool2_mem [0:49];
    logic signed [BITWIDTH-1:0]     conv3_mem [0:9];

    logic [3:0]                     ch_max;
    logic [4:0]                     row_max, col_max;
    logic                           in_max;
    logic [2:0]                     kr_max;
    logic [3:0]                     kc_max;
    logic                           is_pool;
    logic [2:0]                     next_stage;

    logic signed [6:0]              tap_r, tap_c;
    logic signed [BITWIDTH-1:0]     op_a, op_w;
    logic signed [2*BITWIDTH-1:0]   prod;
    logic [10:0]                    c1_base;
    logic [7:0]                     c2_base;
    logic signed [BITWIDTH-1:0]     pin0, pin1, pin2, pin3, pmax01, pmax23, pool_max;
    logic signed [BITWIDTH-1:0]     wb_raw, wb_data;
`ifdef LENET_SATURATE_EN
    logic signed [ACC_W-1:0]        shifted;
`endif

    assign output_vector = output_vector_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);

    // Loop bounds of the current layer (last index of each counter) and the layer that follows
    always_comb begin
        ch_max     = 4'd0;
        row_max    = 5'd0;
        col_max    = 5'd0;
        in_max     = 1'b0;
        kr_max     = 3'd0;
        kc_max     = 4'd0;
        is_pool    = 1'b0;
        next_stage = S_IDLE;
        case (state_q)
            S_CONV1: begin
                ch_max = 4'd1; row_max = 5'd27; col_max = 5'd27;
                kr_max = 3'd4; kc_max = 4'd4; next_stage = S_POOL1;
            end
            S_POOL1: begin
                ch_max = 4'd1; row_max = 5'd13; col_max = 5'd13;
                is_pool = 1'b1; next_stage = S_CONV2;
            end
            S_CONV2: begin
                ch_max = 4'd1; row_max = 5'd9; col_max = 5'd9; in_max = 1'b1;
                kr_max = 3'd4; kc_max = 4'd4; next_stage = S_POOL2;
            end
            S_POOL2: begin
                ch_max = 4'd1; row_max = 5'd4; col_max = 5'd4;
                is_pool = 1'b1; next_stage = S_CONV3;
            end
            S_CONV3: begin
                ch_max = 4'd9; in_max = 1'b1;
                kr_max = 3'd4; kc_max = 4'd4; next_stage = S_FC;
            end
            S_FC: begin
                ch_max = 4'd9; kc_max = 4'd9; next_stage = S_DONE;
            end
            default: ;
        endcase
    end

    // Operand fetch for the MAC; conv1 taps falling in the zero padding read as 0
    always_comb begin
        op_a  = '0;
        op_w  = '0;
        tap_r = 7'({2'b00, row_q}) + 7'({4'b0000, kr_q}) - 7'd2;
        tap_c = 7'({2'b00, col_q}) + 7'({3'b000, kc_q}) - 7'd2;
        case (state_q)
            S_CONV1: begin
                if (!tap_r[6] && (tap_r <= 7'sd27) && !tap_c[6] && (tap_c <= 7'sd27)) begin
                    op_a = image[tap_r[4:0]][tap_c[4:0]];
                end
                op_w = conv1_kernel[ch_q[0]][kr_q][kc_q[2:0]];
            end
            S_CONV2: begin
                op_a = pool1_mem[9'(in_q) * 9'd196 + 9'(row_q + 5'(kr_q)) * 9'd14
                                 + 9'(col_q + 5'(kc_q))];
                op_w = conv2_kernel[ch_q[0]][in_q][kr_q][kc_q[2:0]];
            end
            S_CONV3: begin
                op_a = pool2_mem[6'(in_q) * 6'd25 + 6'(kr_q) * 6'd5 + 6'(kc_q)];
                op_w = conv3_kernel[ch_q][in_q][kr_q][kc_q[2:0]];
            end
            S_FC: begin
                op_a = conv3_mem[kc_q];
                op_w = connect_matrix[ch_q][kc_q];
            end
            default: ;
        endcase
        prod = op_a * op_w;
    end

    // 2x2 max-pool window; the window origin is (2*row, 2*col) of the previous conv map
    always_comb begin
        pin0    = '0;
        pin1    = '0;
        pin2    = '0;
        pin3    = '0;
        c1_base = 11'(ch_q[0]) * 11'd784 + 11'({row_q[3:0], 1'b0}) * 11'd28
                  + 11'({col_q[3:0], 1'b0});
        c2_base = 8'(ch_q[0]) * 8'd100 + 8'({row_q[2:0], 1'b0}) * 8'd10
                  + 8'({col_q[2:0], 1'b0});
        if (state_q == S_POOL1) begin
            pin0 = conv1_mem[c1_base];
            pin1 = conv1_mem[c1_base + 11'd1];
            pin2 = conv1_mem[c1_base + 11'd28];
            pin3 = conv1_mem[c1_base + 11'd29];
        end else if (state_q == S_POOL2) begin
            pin0 = conv2_mem[c2_base];
            pin1 = conv2_mem[c2_base + 8'd1];
            pin2 = conv2_mem[c2_base + 8'd10];
            pin3 = conv2_mem[c2_base + 8'd11];
        end
        pmax01   = (pin0 > pin1) ? pin0 : pin1;
        pmax23   = (pin2 > pin3) ? pin2 : pin3;
        pool_max = (pmax01 > pmax23) ? pmax01 : pmax23;
    end

    // Write-back value: drop the fraction (floor), narrow to BITWIDTH, then ReLU except for FC
    always_comb begin
`ifdef LENET_SATURATE_EN
        shifted = acc_q >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            wb_raw = {1'b0, {(BITWIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            wb_raw = {1'b1, {(BITWIDTH-1){1'b0}}};
        end else begin
            wb_raw = shifted[BITWIDTH-1:0];
        end
`else
        wb_raw = BITWIDTH'(acc_q >>> FRAC_BITS);
`endif
        if ((state_q != S_FC) && wb_raw[BITWIDTH-1]) begin
            wb_data = '0;
        end else begin
            wb_data = wb_raw;
        end
    end

    // Sequencer: conv/FC outputs take their MAC taps then one write cycle, pools write every cycle
    always_comb begin
        state_d         = state_q;
        ch_d            = ch_q;
        row_d           = row_q;
        col_d           = col_q;
        in_d            = in_q;
        kr_d            = kr_q;
        kc_d            = kc_q;
        wr_d            = wr_q;
        acc_d           = acc_q;
        output_vector_d = output_vector_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CONV1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (is_pool || wr_q) begin
                    wr_d  = 1'b0;
                    acc_d = '0;
                    if (state_q == S_FC) begin
                        output_vector_d[ch_q] = wb_data;
                    end
                    if (col_q == col_max) begin
                        col_d = 5'd0;
                        if (row_q == row_max) begin
                            row_d = 5'd0;
                            if (ch_q == ch_max) begin
                                ch_d    = 4'd0;
                                state_d = next_stage;
                            end else begin
                                ch_d = ch_q + 4'd1;
                            end
                        end else begin
                            row_d = row_q + 5'd1;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end else begin
                    acc_d = acc_q + {{(ACC_W-2*BITWIDTH){prod[2*BITWIDTH-1]}}, prod};
                    if (kc_q == kc_max) begin
                        kc_d = 4'd0;
                        if (kr_q == kr_max) begin
                            kr_d = 3'd0;
                            if (in_q == in_max) begin
                                in_d = 1'b0;
                                wr_d = 1'b1;
                            end else begin
                                in_d = 1'b1;
                            end
                        end else begin
                            kr_d = kr_q + 3'd1;
                        end
                    end else begin
                        kc_d = kc_q + 4'd1;
                    end
                end
            end
        endcase
    end

    // Control and accumulator state; reset aborts any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            ch_q            <= '0;
            row_q           <= '0;
            col_q           <= '0;
            in_q            <= 1'b0;
            kr_q            <= '0;
            kc_q            <= '0;
            wr_q            <= 1'b0;
            acc_q           <= '0;
            output_vector_q <= '0;
        end else begin
            state_q         <= state_d;
            ch_q            <= ch_d;
            row_q           <= row_d;
            col_q           <= col_d;
            in_q            <= in_d;
            kr_q            <= kr_d;
            kc_q            <= kc_d;
            wr_q            <= wr_d;
            acc_q           <= acc_d;
            output_vector_q <= output_vector_d;
        end
    end

    // Feature-map buffers; contents are only meaningful within a run, so they are not reset
    always_ff @(posedge clk) begin
        if ((state_q == S_CONV1) && wr_q) begin
            conv1_mem[11'(ch_q[0]) * 11'd784 + 11'(row_q) * 11'd28 + 11'(col_q)] <= wb_data;
        end
        if (state_q == S_POOL1) begin
            pool1_mem[9'(ch_q[0]) * 9'd196 + 9'(row_q) * 9'd14 + 9'(col_q)] <= pool_max;
        end
        if ((state_q == S_CONV2) && wr_q) begin
            conv2_mem[8'(ch_q[0]) * 8'd100 + 8'(row_q) * 8'd10 + 8'(col_q)] <= wb_data;
        end
        if (state_q == S_POOL2) begin
            pool2_mem[6'(ch_q[0]) * 6'd25 + 6'(row_q) * 6'd5 + 6'(col_q)] <= pool_max;
        end
        if ((state_q == S_CONV3) && wr_q) begin
            conv3_mem[ch_q] <= wb_data;
        end
    end

endmodule

// File: tb/tb_lenet_accelerator.sv
// Testbench for lenet_accelerator.
// Random image/weights are applied; a reference model computes the ten class
// scores directly from the layer definitions and pushes them, with the cycle
// at which done must appear, onto a scoreboard queue. An independent monitor
// pops and compares whenever done is seen.

module tb_lenet_accelerator;

    localparam int BW         = 16;
    localparam int FRAC       = 8;
    localparam int RUN_CYCLES = 52030;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              start;
    logic [27:0][27:0][BW-1:0]         image;
    logic [1:0][4:0][4:0][BW-1:0]      conv1_kernel;
    logic [1:0][1:0][4:0][4:0][BW-1:0] conv2_kernel;
    logic [9:0][1:0][4:0][4:0][BW-1:0] conv3_kernel;
    logic [9:0][9:0][BW-1:0]           connect_matrix;
    logic [9:0][BW-1:0]                output_vector;
    logic                              busy;
    logic                              done;

    typedef struct {
        int vals[10];
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_seen = 0;

    int m_c1[2][28][28];
    int m_p1[2][14][14];
    int m_c2[2][10][10];
    int m_p2[2][5][5];
    int m_c3[10];
    int model_out[10];

    lenet_accelerator #(.BITWIDTH(BW), .FRAC_BITS(FRAC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .image          (image),
        .conv1_kernel   (conv1_kernel),
        .conv2_kernel   (conv2_kernel),
        .conv3_kernel   (conv3_kernel),
        .connect_matrix (connect_matrix),
        .output_vector  (output_vector),
        .busy           (busy),
        .done           (done)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Floor-shift, narrow to 16 bits (clamp or wrap), optional ReLU
    function automatic int wb(input longint acc, input bit relu);
        longint s;
        int     r;
        s = acc >>> FRAC;
`ifdef LENET_SATURATE_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        r = int'(s);
`else
        r = int'(shortint'(s));
`endif
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Reference network evaluated straight from the layer definitions
    task automatic compute_model();
        longint acc;
        int     ir, ic;
        for (int o = 0; o < 2; o++)
            for (int r = 0; r < 28; r++)
                for (int c = 0; c < 28; c++) begin
                    acc = 0;
                    for (int kr = 0; kr < 5; kr++)
                        for (int kc = 0; kc < 5; kc++) begin
                            ir = r + kr - 2;
                            ic = c + kc - 2;
                            if (ir >= 0 && ir < 28 && ic >= 0 && ic < 28)
                                acc += longint'($signed(image[ir][ic]))
                                       * longint'($signed(conv1_kernel[o][kr][kc]));
                        end
                    m_c1[o][r][c] = wb(acc, 1'b1);
                end
        for (int o = 0; o < 2; o++)
            for (int r = 0; r < 14; r++)
                for (int c = 0; c < 14; c++)
                    m_p1[o][r][c] = max4(m_c1[o][2*r][2*c], m_c1[o][2*r][2*c+1],
                                         m_c1[o][2*r+1][2*c], m_c1[o][2*r+1][2*c+1]);
        for (int o = 0; o < 2; o++)
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 10; c++) begin
                    acc = 0;
                    for (int i = 0; i < 2; i++)
                        for (int kr = 0; kr < 5; kr++)
                            for (int kc = 0; kc < 5; kc++)
                                acc += longint'(m_p1[i][r+kr][c+kc])
                                       * longint'($signed(conv2_kernel[o][i][kr][kc]));
                    m_c2[o][r][c] = wb(acc, 1'b1);
                end
        for (int o = 0; o < 2; o++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    m_p2[o][r][c] = max4(m_c2[o][2*r][2*c], m_c2[o][2*r][2*c+1],
                                         m_c2[o][2*r+1][2*c], m_c2[o][2*r+1][2*c+1]);
        for (int o = 0; o < 10; o++) begin
            acc = 0;
            for (int i = 0; i < 2; i++)
                for (int kr = 0; kr < 5; kr++)
                    for (int kc = 0; kc < 5; kc++)
                        acc += longint'(m_p2[i][kr][kc])
                               * longint'($signed(conv3_kernel[o][i][kr][kc]));
            m_c3[o] = wb(acc, 1'b1);
        end
        for (int o = 0; o < 10; o++) begin
            acc = 0;
            for (int j = 0; j < 10; j++)
                acc += longint'($signed(connect_matrix[o][j])) * longint'(m_c3[j]);
            model_out[o] = wb(acc, 1'b0);
        end
    endtask

    // Random image and weights; FC rows 0/1 use large weights to push scores past 16 bits
    task automatic applyStimulus();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                image[r][c] = BW'(int'($urandom_range(0, 1023)) - 512);
        for (int o = 0; o < 2; o++)
            for (int kr = 0; kr < 5; kr++)
                for (int kc = 0; kc < 5; kc++)
                    conv1_kernel[o][kr][kc] = BW'(int'($urandom_range(0, 255)) - 128);
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 2; i++)
                for (int kr = 0; kr < 5; kr++)
                    for (int kc = 0; kc < 5; kc++)
                        conv2_kernel[o][i][kr][kc] = BW'(int'($urandom_range(0, 255)) - 128);
        for (int o = 0; o < 10; o++)
            for (int i = 0; i < 2; i++)
                for (int kr = 0; kr < 5; kr++)
                    for (int kc = 0; kc < 5; kc++)
                        conv3_kernel[o][i][kr][kc] = BW'(int'($urandom_range(0, 255)) - 128);
        for (int o = 0; o < 10; o++)
            for (int j = 0; j < 10; j++) begin
                if (o == 0)
                    connect_matrix[o][j] = BW'(int'($urandom_range(20000, 32767)));
                else if (o == 1)
                    connect_matrix[o][j] = BW'(-int'($urandom_range(20000, 32767)));
                else
                    connect_matrix[o][j] = BW'(int'($urandom_range(0, 511)) - 256);
            end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'sd1, 32'sd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("done_cycle", cyc, e.due);
                for (int i = 0; i < 10; i++)
                    checkOutput($sformatf("out[%0d]", i), $signed(output_vector[i]), e.vals[i]);
            end
        end
    end

    // Main sequence: reset state, aborted run, full run with an ignored second start
    initial begin
        exp_t e;
        int   start_cyc;
        int   n;
        rst_n          = 1'b0;
        start          = 1'b0;
        image          = '0;
        conv1_kernel   = '0;
        conv2_kernel   = '0;
        conv3_kernel   = '0;
        connect_matrix = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        for (int i = 0; i < 10; i++)
            checkOutput($sformatf("reset_out[%0d]", i), $signed(output_vector[i]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", busy, 0);

        // Run that gets aborted by reset around cycle 1000
        applyStimulus();
        start_cyc = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("abort_run_busy", busy, 1);
        while (cyc < start_cyc + 1000) @(negedge clk);
        checkOutput("abort_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        for (int i = 0; i < 10; i++)
            checkOutput($sformatf("abort_out[%0d]", i), $signed(output_vector[i]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_stays_idle", busy, 0);

        // Full run with fresh random data
        applyStimulus();
        compute_model();
        @(negedge clk);
        start_cyc = cyc;
        e.vals    = model_out;
        e.due     = start_cyc + 1 + RUN_CYCLES;
        exp_q.push_back(e);
        $display("[TB] run start at cycle %0d, done due at %0d", start_cyc, e.due);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("run_busy", busy, 1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("run_busy_after_restart", busy, 1);

        n = 0;
        while (!done && n < RUN_CYCLES + 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput("done_timeout", 32'sd0, 32'sd1);
        @(negedge clk);
        checkOutput("post_busy", busy, 0);
        checkOutput("post_done", done, 0);
        repeat (5) @(negedge clk);
        checkOutput("done_count", done_seen, 1);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
